byte_serial_logic_unit: RTL
===========================

Name: byte_serial_logic_unit

Overview:
Multi-cycle bitwise logic unit for the area-reduced ALU variant. Reuses one SLICE_W-bit logic slice over DATA_W/SLICE_W cycles instead of DATA_W/SLICE_W parallel slices. Accepts two operands plus an opcode on a valid/ready handshake and returns the DATA_W-bit result on a second valid/ready handshake. Sits between the ALU operand mux and the writeback mux; the control unit stalls while it is busy.

Parameters:
DATA_W, 32, operand/result width; must be an integer multiple of SLICE_W
SLICE_W, 8, width of the single logic slice processed per cycle

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands/opcode present
in_ready  output  1  unit can accept a new operation
op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR
in1  input  DATA_W  operand A
in2  input  DATA_W  operand B
out_valid  output  1  result present on out
out_ready  input  1  consumer takes result
out  output  DATA_W  result
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n low at a rising edge): state IDLE, slice index 0, accumulator 0. out = 0, out_valid = 0, busy = 0, in_ready = 1 after the edge.
- Reset overrides every other input. A reset mid-RUN or in DONE aborts the operation, discards the result, and does not assert out_valid.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: capture in1, in2 and op into internal registers, clear the accumulator, set index = 0, go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge: accumulator[index*SLICE_W +: SLICE_W] = f(op, A slice, B slice), where f is AND, OR, XOR or NOR.
  - Slices are processed LSB first; index increments each edge.
  - After the slice with index DATA_W/SLICE_W-1, copy the full result to out and go to DONE.
  - The edge that writes the last slice also updates out, so out is updated atomically.
  - Port inputs in1, in2, op and in_valid are ignored during RUN; the captured values are used.
- DONE:
  - out_valid = 1, in_ready = 0.
  - On an edge with out_ready = 1: out_valid drops and the unit goes to IDLE.
  - No new operation is accepted in the same cycle as the result handshake.
  - out_valid remains high indefinitely while out_ready = 0 (backpressure).
- Latency: out_valid rises exactly DATA_W/SLICE_W edges after the acceptance edge (4 with defaults). Minimum issue interval is DATA_W/SLICE_W + 2 cycles.
- out holds the last completed result from entry into DONE until the next completion or reset. out is never modified during RUN.
- busy = (state != IDLE).
- Index counter width: clog2(DATA_W/SLICE_W), minimum 1 bit. No wrap is used beyond the last slice index.
- out_ready while not in DONE has no effect. in_valid while in_ready = 0 has no effect and does not queue.

Optional Feature:
Macro BSLU_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit).
  - zero is registered and updated on the same edge as out: 1 if the full result equals 0, else 0.
  - zero resets to 0 and holds between completions.
- Undefined: the zero port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, then AND: in1=0xF0F0_1234, in2=0xFF00_00FF, op=00, in_valid pulse -> out_valid high 4 edges after acceptance; out=0xF000_0034; busy high from acceptance until the handshake.
- OR/XOR/NOR with in1=0xA5A5_A5A5, in2=0x0F0F_F0F0 -> out=0xAFAF_F5F5, 0xAAAA_5555 and 0x5050_0A0A respectively.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out stable; in_ready stays 0; a new in_valid is ignored; out_ready=1 gives IDLE on the next edge.
- Operand change mid-RUN: alter in1/in2/op on the cycle after acceptance -> result matches the captured values.
- Reset mid-RUN after 2 slices -> out=0, out_valid never asserts, in_ready=1 after the reset edge; a fresh operation then completes correctly.
- With BSLU_ZERO_FLAG_EN: XOR of 0x1234_5678 with itself -> out=0, zero=1; a following AND 0xFFFF_FFFF & 0x1 -> zero=0.

Source files
------------

// File: rtl/byte_serial_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE_W-bit slice is processed per clock, LSB first.
// Optional zero flag output is enabled by defining BSLU_ZERO_FLAG_EN.

module byte_serial_logic_unit #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              busy
`ifdef BSLU_ZERO_FLAG_EN
    ,
    output logic              zero
`endif
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         op_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  acc_next;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] res_sl;
    logic               accept;
    logic               last_slice;

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
    assign accept     = in_valid & in_ready;
    assign last_slice = (idx == LAST_IDX);

    // The one shared logic slice, fed from the captured operands at the current index.
    always_comb begin
        a_sl = a_q[SLICE_W*int'(idx) +: SLICE_W];
        b_sl = b_q[SLICE_W*int'(idx) +: SLICE_W];
        case (op_q)
            OP_AND:  res_sl = a_sl & b_sl;
            OP_OR:   res_sl = a_sl | b_sl;
            OP_XOR:  res_sl = a_sl ^ b_sl;
            default: res_sl = ~(a_sl | b_sl);
        endcase
        acc_next = acc;
        acc_next[SLICE_W*int'(idx) +: SLICE_W] = res_sl;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            out   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q   <= in1;
                        b_q   <= in2;
                        op_q  <= op;
                        acc   <= '0;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    // out only changes here, on the edge that writes the final slice.
                    if (last_slice) begin
                        out   <= acc_next;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BSLU_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero <= 1'b0;
        end else if (state == ST_RUN && last_slice) begin
            zero <= (acc_next == '0);
        end
    end
`endif

endmodule
